mem_stage_pipe: RTL and testbench
=================================

// Module: mem_stage_pipe
// PURPOSE
//  Parametrised data-memory pipeline stage for the dual-issue core: byte-enable data RAM plus a
//  LAT-deep sideband pipeline carrying the instruction word and per-lane writeback tags/data.
//  Sits between execute and writeback. Single-edge (posedge) RAM access, selectable stall policy,
//  same-cycle store-to-load merge.
// PARAMETERS
//  ADDR_W     15  word-index bits; RAM depth = 2**ADDR_W words
//  DATA_W     64  RAM word width (multiple of 8)
//  INST_W     64  instruction bundle width (multiple of 32)
//  LANES       2  writeback lanes
//  REG_W       5  register-tag width
//  TDATA_W    32  per-lane pass-through data width
//  LAT         2  pipeline depth, inst -> inst_out (>=1)
//  HOLD_MODE   0  0: interlock drains a bubble at output; 1: interlock freezes all outputs
// PORTS
//  clk          in   1              clock; all state on posedge
//  rstn         in   1              async active-low reset
//  interlock    in   1              stall from downstream/hazard unit
//  mem_used     in   1              bundle carries a memory op
//  inst         in   INST_W         instruction bundle
//  wr_addr      in   32             byte address of store
//  wr_data      in   DATA_W         store data
//  wr_be        in   DATA_W/8       store byte enables
//  rd_addr      in   32             byte address of load
//  rd_en        in   1              load request
//  rt           in   LANES*REG_W    per-lane dest tag
//  rt_flag      in   LANES          per-lane writeback enable
//  tdata        in   LANES*TDATA_W  per-lane result data
//  inst_out     out  INST_W         bundle, LAT cycles later
//  rt_out       out  LANES*REG_W    delayed rt
//  rt_flag_out  out  LANES          delayed rt_flag
//  tdata_out    out  LANES*TDATA_W  delayed tdata
//  rd_data      out  DATA_W         load result, aligned with inst_out
//  rd_valid     out  1              rd_data belongs to inst_out
//  fwd_hit      out  1              rd_data was merged from same-cycle store
// BEHAVIOUR
//  - Word index = addr[ADDR_W+2:3]; upper bits ignored. NOP = {3'b111,29'b0} per 32-bit slice.
//  - Reset (async): every stage inst=NOP, rt/rt_flag/tdata=0; outputs equal the last stage, so
//    inst_out=NOP, all flags/data 0, rd_valid=0, fwd_hit=0, rd_data=0. RAM contents undefined,
//    not cleared; no write while rstn=0.
//  - Advance (interlock=0): stage0 <- inputs, stage k <- stage k-1; output = stage LAT-1.
//  - Write commits on the accepting edge iff ~interlock & mem_used & rstn; only bytes with
//    wr_be=1 change.
//  - Read samples rd_addr on the accepting edge; tagged rd_valid = rd_en & mem_used and carried
//    with the bundle; rd_data presented LAT cycles later alongside inst_out.
//  - Same-cycle collision (accepted read and write, same word index): read returns pre-store
//    word with bytes where wr_be=1 replaced by wr_data; fwd_hit=1 travels with that bundle.
//    Writes in earlier cycles are visible to later reads without merge.
//  - interlock=1, HOLD_MODE=0: no input accepted, no RAM write; stages 0..LAT-2 hold; output
//    stage loads NOP, rt_flag_out=0, rd_valid=0, fwd_hit=0 (rd_data, rt_out, tdata_out hold).
//    On release, the held stage LAT-2 bundle reaches the output after one edge; none lost.
//    LAT=1: nothing held, input dropped.
//  - interlock=1, HOLD_MODE=1: no input accepted, no write; every stage and output, including
//    rd_data, holds bit-exact for the whole stall.
//  - rd_data must come from a register at or after the RAM output so HOLD_MODE stalls cannot
//    corrupt it.
//  - Reset asserted mid-stall or mid-flight: all in-flight bundles discarded immediately.
//    First accepted bundle after release emerges LAT cycles later.
// TESTING
//  1 Store be=0xFF data=0x1122334455667788 @0x40, next cycle load @0x40 -> rd_data matches
//    after LAT cycles, rd_valid=1, fwd_hit=0.
//  2 Word 0x40 = 0; same-cycle store be=0x0F data=0xAAAAAAAA_BBBBBBBB and load @0x40 ->
//    rd_data=0x00000000_BBBBBBBB, fwd_hit=1.
//  3 HOLD_MODE=0, LAT=2, bundles A,B,C back-to-back, interlock=1 for 3 cycles after B accepted
//    -> inst_out A, NOP x3, B, C; rt_flag_out=0 on NOPs; no extra RAM write.
//  4 HOLD_MODE=1, same stimulus -> inst_out/rd_data/tdata_out frozen 3 cycles, then B, C.
//  5 Store issued with interlock=1 -> subsequent load returns old word.
//  6 rstn pulled low mid-flight with LAT=3 -> next edge-free check: inst_out=NOP, flags 0,
//    rd_valid=0 while low; first bundle after release at cycle +3.

Source files
------------

// File: rtl/mem_stage_pipe.sv
// Memory pipeline stage: byte-enable data RAM with same-cycle store-to-load merge and a
// LAT-deep sideband pipeline that keeps each load result aligned with its instruction bundle.
module mem_stage_pipe #(
  parameter int ADDR_W    = 15,
  parameter int DATA_W    = 64,
  parameter int INST_W    = 64,
  parameter int LANES     = 2,
  parameter int REG_W     = 5,
  parameter int TDATA_W   = 32,
  parameter int LAT       = 2,
  parameter int HOLD_MODE = 0
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       interlock,
  input  logic                       mem_used,
  input  logic [INST_W-1:0]          inst,
  input  logic [31:0]                wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [DATA_W/8-1:0]        wr_be,
  input  logic [31:0]                rd_addr,
  input  logic                       rd_en,
  input  logic [LANES*REG_W-1:0]     rt,
  input  logic [LANES-1:0]           rt_flag,
  input  logic [LANES*TDATA_W-1:0]   tdata,
  output logic [INST_W-1:0]          inst_out,
  output logic [LANES*REG_W-1:0]     rt_out,
  output logic [LANES-1:0]           rt_flag_out,
  output logic [LANES*TDATA_W-1:0]   tdata_out,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  output logic                       fwd_hit
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [INST_W-1:0] NOP = {(INST_W / 32){32'hE000_0000}};

  typedef struct packed {
    logic [INST_W-1:0]        inst;
    logic [LANES*REG_W-1:0]   rt;
    logic [LANES-1:0]         rt_flag;
    logic [LANES*TDATA_W-1:0] tdata;
    logic [DATA_W-1:0]        rd_data;
    logic                     rd_valid;
    logic                     fwd_hit;
  } stage_t;

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] wr_idx;
  logic [ADDR_W-1:0] rd_idx;
  logic              accept;
  logic              wr_commit;
  logic              collide;
  logic [DATA_W-1:0] rd_word;
  stage_t            in_stage;
  stage_t            pipe [LAT];

  assign wr_idx    = wr_addr[ADDR_W+2:3];
  assign rd_idx    = rd_addr[ADDR_W+2:3];
  assign accept    = ~interlock;
  assign wr_commit = accept & mem_used;
  assign collide   = wr_commit & (wr_idx == rd_idx);

  // Address bits outside the word index are ignored by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{wr_addr[31:ADDR_W+3], wr_addr[2:0],
                              rd_addr[31:ADDR_W+3], rd_addr[2:0]};

  // NOTE: the RAM array is deliberately left out of reset; clearing it would force a
  // flop-based implementation. Only the gated write below ever changes it.
  always_ff @(posedge clk) begin
    if (rstn && wr_commit) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Pre-store word with the colliding store's enabled bytes spliced in.
  // NOTE: every variable gets a default at the top of the block so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_word = mem[rd_idx];
    for (int b = 0; b < BE_W; b++) begin
      if (collide && wr_be[b]) rd_word[8*b +: 8] = wr_data[8*b +: 8];
    end
  end

  always_comb begin
    in_stage          = '0;
    in_stage.inst     = inst;
    in_stage.rt       = rt;
    in_stage.rt_flag  = rt_flag;
    in_stage.tdata    = tdata;
    in_stage.rd_data  = rd_word;
    in_stage.rd_valid = rd_en & mem_used;
    in_stage.fwd_hit  = rd_en & mem_used & collide;
  end

  // NOTE: state registers use non-blocking assignments so every stage samples the
  // pre-edge value of its predecessor; combinational blocks above use blocking ones.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < LAT; k++) pipe[k] <= '{inst: NOP, default: '0};
    end else if (accept) begin
      pipe[0] <= in_stage;
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end else if (HOLD_MODE == 0) begin
      // Drain a bubble: inner stages hold, output stage turns into an inert NOP.
      pipe[LAT-1].inst     <= NOP;
      pipe[LAT-1].rt_flag  <= '0;
      pipe[LAT-1].rd_valid <= 1'b0;
      pipe[LAT-1].fwd_hit  <= 1'b0;
    end
  end

  assign inst_out    = pipe[LAT-1].inst;
  assign rt_out      = pipe[LAT-1].rt;
  assign rt_flag_out = pipe[LAT-1].rt_flag;
  assign tdata_out   = pipe[LAT-1].tdata;
  assign rd_data     = pipe[LAT-1].rd_data;
  assign rd_valid    = pipe[LAT-1].rd_valid;
  assign fwd_hit     = pipe[LAT-1].fwd_hit;

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Bench for mem_stage_pipe: two instances (LAT=2 bubble-drain, LAT=3 freeze) driven with the
// same stimulus and compared against a history/associative-array reference model.
module tb_mem_stage_pipe;

  localparam int AW = 6, DW = 64, IW = 64, LN = 2, RW = 5, TW = 32;
  localparam int LAT0 = 2, LAT1 = 3;
  localparam logic [IW-1:0] NOP = {2{32'hE000_0000}};

  typedef struct packed {
    logic [IW-1:0]    inst;
    logic [LN*RW-1:0] rt;
    logic [LN-1:0]    rt_flag;
    logic [LN*TW-1:0] tdata;
    logic [DW-1:0]    rd_data;
    logic             rd_valid;
    logic             fwd_hit;
  } rec_t;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             interlock = 1'b0;
  logic             mem_used = 1'b0;
  logic [IW-1:0]    inst = '0;
  logic [31:0]      wr_addr = '0;
  logic [DW-1:0]    wr_data = '0;
  logic [DW/8-1:0]  wr_be = '0;
  logic [31:0]      rd_addr = '0;
  logic             rd_en = 1'b0;
  logic [LN*RW-1:0] rt = '0;
  logic [LN-1:0]    rt_flag = '0;
  logic [LN*TW-1:0] tdata = '0;

  logic [IW-1:0] o0_inst, o1_inst;
  logic [LN*RW-1:0] o0_rt, o1_rt;
  logic [LN-1:0] o0_rt_flag, o1_rt_flag;
  logic [LN*TW-1:0] o0_tdata, o1_tdata;
  logic [DW-1:0] o0_rd_data, o1_rd_data;
  logic o0_rd_valid, o1_rd_valid, o0_fwd_hit, o1_fwd_hit;
  rec_t got0, got1;

  assign got0 = {o0_inst, o0_rt, o0_rt_flag, o0_tdata, o0_rd_data, o0_rd_valid, o0_fwd_hit};
  assign got1 = {o1_inst, o1_rt, o1_rt_flag, o1_tdata, o1_rd_data, o1_rd_valid, o1_fwd_hit};

  mem_stage_pipe #(.ADDR_W(AW), .DATA_W(DW), .INST_W(IW), .LANES(LN), .REG_W(RW),
                   .TDATA_W(TW), .LAT(LAT0), .HOLD_MODE(0)) u_drain (
    .clk(clk), .rstn(rstn), .interlock(interlock), .mem_used(mem_used), .inst(inst),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be), .rd_addr(rd_addr), .rd_en(rd_en),
    .rt(rt), .rt_flag(rt_flag), .tdata(tdata), .inst_out(o0_inst), .rt_out(o0_rt),
    .rt_flag_out(o0_rt_flag), .tdata_out(o0_tdata), .rd_data(o0_rd_data),
    .rd_valid(o0_rd_valid), .fwd_hit(o0_fwd_hit));

  mem_stage_pipe #(.ADDR_W(AW), .DATA_W(DW), .INST_W(IW), .LANES(LN), .REG_W(RW),
                   .TDATA_W(TW), .LAT(LAT1), .HOLD_MODE(1)) u_freeze (
    .clk(clk), .rstn(rstn), .interlock(interlock), .mem_used(mem_used), .inst(inst),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be), .rd_addr(rd_addr), .rd_en(rd_en),
    .rt(rt), .rt_flag(rt_flag), .tdata(tdata), .inst_out(o1_inst), .rt_out(o1_rt),
    .rt_flag_out(o1_rt_flag), .tdata_out(o1_tdata), .rd_data(o1_rd_data),
    .rd_valid(o1_rd_valid), .fwd_hit(o1_fwd_hit));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: word-addressed memory, a history of accepted bundles indexed by the
  // number of accepting edges since reset, and the currently expected output of each instance.
  logic [DW-1:0] mem_m [int];
  rec_t hist [16];
  int   adv = 0;
  rec_t exp0, exp1;

  function automatic rec_t reset_rec();
    rec_t r = '0;
    r.inst = NOP;
    return r;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 3) & ((32'd1 << AW) - 1));
  endfunction

  function automatic rec_t delayed(input int lat);
    int j = adv - lat + 1;
    if (j < 1) return reset_rec();
    return hist[j % 16];
  endfunction

  task automatic model_reset();
    adv  = 0;
    exp0 = reset_rec();
    exp1 = reset_rec();
  endtask

  task automatic model_edge();
    rec_t r;
    int wi, ri;
    logic coll;
    logic [DW-1:0] w;
    if (!rstn) return;
    if (interlock) begin
      exp0.inst = NOP;
      exp0.rt_flag = '0;
      exp0.rd_valid = 1'b0;
      exp0.fwd_hit = 1'b0;
      return;
    end
    wi = widx(wr_addr);
    ri = widx(rd_addr);
    coll = mem_used && (wi == ri);
    w = mem_m.exists(ri) ? mem_m[ri] : '0;
    for (int b = 0; b < DW / 8; b++)
      if (coll && wr_be[b]) w[8*b +: 8] = wr_data[8*b +: 8];
    r.inst = inst;
    r.rt = rt;
    r.rt_flag = rt_flag;
    r.tdata = tdata;
    r.rd_data = w;
    r.rd_valid = rd_en && mem_used;
    r.fwd_hit = rd_en && mem_used && coll;
    if (mem_used) begin
      w = mem_m.exists(wi) ? mem_m[wi] : '0;
      for (int b = 0; b < DW / 8; b++)
        if (wr_be[b]) w[8*b +: 8] = wr_data[8*b +: 8];
      mem_m[wi] = w;
    end
    adv++;
    hist[adv % 16] = r;
    exp0 = delayed(LAT0);
    exp1 = delayed(LAT1);
  endtask

  task automatic cmp(input string d, input rec_t g, input rec_t e);
    check({d, ".inst"}, g.inst, e.inst);
    check({d, ".rt"}, g.rt, e.rt);
    check({d, ".rt_flag"}, g.rt_flag, e.rt_flag);
    check({d, ".tdata"}, g.tdata, e.tdata);
    check({d, ".rd_data"}, g.rd_data, e.rd_data);
    check({d, ".rd_valid"}, g.rd_valid, e.rd_valid);
    check({d, ".fwd_hit"}, g.fwd_hit, e.fwd_hit);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cmp("drain", got0, exp0);
    cmp("freeze", got1, exp1);
  endtask

  task automatic drive(input logic il, input logic mu, input logic [IW-1:0] ins,
                       input logic [31:0] wa, input logic [DW-1:0] wd, input logic [7:0] be,
                       input logic [31:0] ra, input logic re);
    interlock = il;
    mem_used  = mu;
    inst      = ins;
    wr_addr   = wa;
    wr_data   = wd;
    wr_be     = be;
    rd_addr   = ra;
    rd_en     = re;
    rt        = (LN*RW)'($urandom);
    rt_flag   = LN'($urandom);
    tdata     = {$urandom, $urandom};
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, {$urandom, $urandom}, 32'h0, '0, 8'h00, 32'h0, 1'b0);
  endtask

  // Enter reset at a negedge, check the asynchronous clear, hold for n edges, release.
  task automatic pulse_reset(input int n);
    rstn = 1'b0;
    #1;
    model_reset();
    cmp("rst_drain", got0, exp0);
    cmp("rst_freeze", got1, exp1);
    for (int i = 0; i < n; i++) step();
    rstn = 1'b1;
  endtask

  initial begin
    logic [IW-1:0] a_inst, b_inst, c_inst, d_inst;
    logic [31:0] wa;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp("reset_drain", got0, exp0);
    cmp("reset_freeze", got1, exp1);
    check("reset.inst_nop", o0_inst, NOP);
    rstn = 1'b1;

    // Fill every word; read address equals write address so the merged result is fully known.
    for (int w = 0; w < (1 << AW); w++) begin
      wa = ($urandom & ~32'h1F8) | (32'(w) << 3);
      drive(1'b0, 1'b1, {$urandom, $urandom}, wa, {$urandom, $urandom}, 8'hFF, wa, 1'b0);
      step();
    end

    // Store then load in the following cycle: no merge.
    drive(1'b0, 1'b1, 64'h1, 32'h40, 64'h1122334455667788, 8'hFF, 32'h100, 1'b0);
    step();
    drive(1'b0, 1'b1, 64'h2, 32'h108, '0, 8'h00, 32'h40, 1'b1);
    step();
    idle();
    step();
    check("t1.rd_data", o0_rd_data, 64'h1122334455667788);
    check("t1.rd_valid", o0_rd_valid, 1'b1);
    check("t1.fwd_hit", o0_fwd_hit, 1'b0);
    step();
    check("t1.rd_data_lat3", o1_rd_data, 64'h1122334455667788);

    // Same-cycle partial store and load to the same word: merged result.
    drive(1'b0, 1'b1, 64'h3, 32'h40, '0, 8'hFF, 32'h100, 1'b0);
    step();
    drive(1'b0, 1'b1, 64'h4, 32'h40, 64'hAAAAAAAA_BBBBBBBB, 8'h0F, 32'h40, 1'b1);
    step();
    idle();
    step();
    check("t2.rd_data", o0_rd_data, 64'h00000000_BBBBBBBB);
    check("t2.fwd_hit", o0_fwd_hit, 1'b1);

    // A, B, three stalled cycles carrying a store, then C loading the stalled store's word.
    a_inst = 64'hA0A0_0000_0000_000A;
    b_inst = 64'hB0B0_0000_0000_000B;
    c_inst = 64'hC0C0_0000_0000_000C;
    idle();
    step();
    drive(1'b0, 1'b1, a_inst, 32'h48, 64'h0123456789ABCDEF, 8'hFF, 32'h200, 1'b0);
    step();
    drive(1'b0, 1'b0, b_inst, 32'h0, '0, 8'h00, 32'h0, 1'b0);
    step();
    check("t3.out_a", o0_inst, a_inst);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 64'hDEAD, 32'h48, 64'hDEADBEEF_DEADBEEF, 8'hFF, 32'h48, 1'b1);
      step();
      check("t3.bubble_nop", o0_inst, NOP);
      check("t3.bubble_flag", o0_rt_flag, '0);
    end
    drive(1'b0, 1'b1, c_inst, 32'h400, '0, 8'h00, 32'h48, 1'b1);
    step();
    check("t3.out_b", o0_inst, b_inst);
    check("t4.out_a", o1_inst, a_inst);
    idle();
    step();
    check("t3.out_c", o0_inst, c_inst);
    check("t5.old_word", o0_rd_data, 64'h0123456789ABCDEF);
    check("t4.out_b", o1_inst, b_inst);
    idle();
    step();
    check("t4.out_c", o1_inst, c_inst);

    // Reset with bundles in flight; first bundle after release emerges LAT edges later.
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, {$urandom, $urandom}, $urandom, {$urandom, $urandom}, 8'($urandom),
            $urandom, 1'b1);
      step();
    end
    pulse_reset(2);
    check("t6.rd_valid_low", o1_rd_valid, 1'b0);
    d_inst = 64'hD0D0_0000_0000_000D;
    drive(1'b0, 1'b0, d_inst, 32'h0, '0, 8'h00, 32'h0, 1'b0);
    step();
    idle();
    step();
    check("t6.drain_d", o0_inst, d_inst);
    step();
    check("t6.freeze_d", o1_inst, d_inst);

    // Randomized traffic with occasional stalls, collisions and resets.
    for (int i = 0; i < 800; i++) begin
      logic [31:0] ra;
      wa = $urandom;
      ra = ($urandom_range(3) == 0) ? ((wa & 32'h1F8) | ($urandom & ~32'h1F8)) : $urandom;
      drive($urandom_range(4) == 0, $urandom_range(9) < 7, {$urandom, $urandom}, wa,
            {$urandom, $urandom}, 8'($urandom), ra, $urandom_range(9) < 7);
      step();
      if ($urandom_range(99) == 0) pulse_reset($urandom_range(2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
